// File: rtl/hci_mem_bank_ctrl_pkg.sv
// Shared types for the HCI memory bank controller.
// The sleep/wake logic using these is compiled in only with HCI_BANK_SLEEP_EN.
package hci_package;

    typedef enum logic [1:0] {
        ACTIVE = 2'd0,
        SLEEP  = 2'd1,
        WAKE   = 2'd2
    } hci_bank_state_t;

    // Width holding every count up to the larger of the two thresholds.
    function automatic int unsigned cnt_width(input int unsigned a, input int unsigned b);
        return $clog2(((a > b) ? a : b) + 1);
    endfunction

endpackage

// File: rtl/hci_mem_bank_ctrl_sleep_fsm.sv
// Bank power FSM (ACTIVE/SLEEP/WAKE) with idle and wake counters.
// HCI_BANK_SLEEP_EN compiles the FSM in; otherwise the bank is permanently active.
module hci_bank_sleep_fsm
    import hci_package::*;
#(
    parameter int unsigned IDLE_CYCLES = 16,
    parameter int unsigned WAKE_CYCLES = 4
) (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_clear,
    input  logic i_req,
    output logic o_active,
    output logic o_sleep
);

`ifdef HCI_BANK_SLEEP_EN
    localparam int unsigned CW = cnt_width(IDLE_CYCLES, WAKE_CYCLES);
    localparam logic [CW-1:0] IdleLast = CW'(IDLE_CYCLES - 1);
    localparam logic [CW-1:0] WakeLast = CW'(WAKE_CYCLES - 1);
    localparam logic [CW-1:0] CntSat   = {CW{1'b1}};

    hci_bank_state_t r_state, w_state_d;
    logic [CW-1:0]   r_idle_cnt, w_idle_cnt_d;
    logic [CW-1:0]   r_wake_cnt, w_wake_cnt_d;

    always_comb begin
        w_state_d    = r_state;
        w_idle_cnt_d = r_idle_cnt;
        w_wake_cnt_d = r_wake_cnt;
        case (r_state)
            ACTIVE: begin
                if (i_req) begin
                    w_idle_cnt_d = '0;
                end else if (r_idle_cnt == IdleLast) begin
                    // This cycle is the last idle one allowed before sleeping.
                    w_state_d    = SLEEP;
                    w_idle_cnt_d = '0;
                end else if (r_idle_cnt != CntSat) begin
                    w_idle_cnt_d = r_idle_cnt + 1'b1;
                end
            end
            SLEEP: begin
                if (i_req) begin
                    w_state_d    = WAKE;
                    w_wake_cnt_d = '0;
                end
            end
            WAKE: begin
                // Wake runs to completion whether or not the request is still held.
                if (r_wake_cnt == WakeLast) begin
                    w_state_d    = ACTIVE;
                    w_wake_cnt_d = '0;
                    w_idle_cnt_d = '0;
                end else if (r_wake_cnt != CntSat) begin
                    w_wake_cnt_d = r_wake_cnt + 1'b1;
                end
            end
            default: begin
                w_state_d    = ACTIVE;
                w_idle_cnt_d = '0;
                w_wake_cnt_d = '0;
            end
        endcase
        if (i_clear) begin
            w_state_d    = ACTIVE;
            w_idle_cnt_d = '0;
            w_wake_cnt_d = '0;
        end
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_state    <= ACTIVE;
            r_idle_cnt <= '0;
            r_wake_cnt <= '0;
        end else begin
            r_state    <= w_state_d;
            r_idle_cnt <= w_idle_cnt_d;
            r_wake_cnt <= w_wake_cnt_d;
        end
    end

    assign o_active = (r_state == ACTIVE);
    assign o_sleep  = (r_state == SLEEP);
`else
    logic w_unused_inputs;
    assign w_unused_inputs = ^{i_clk, i_rst_n, i_clear, i_req};

    assign o_active = 1'b1;
    assign o_sleep  = 1'b0;
`endif

endmodule

// File: rtl/hci_mem_bank_ctrl.sv
// HCI memory bank controller: SRAM passthrough, one-cycle read response register,
// and optional idle sleep (enabled by defining HCI_BANK_SLEEP_EN).
module hci_mem_bank_ctrl
    import hci_package::*;
#(
    parameter int unsigned AW          = 32,
    parameter int unsigned DW          = 32,
    parameter int unsigned BW          = 8,
    parameter int unsigned IW          = 20,
    parameter int unsigned IDLE_CYCLES = 16,
    parameter int unsigned WAKE_CYCLES = 4
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             clear_i,
    input  logic             req_i,
    output logic             gnt_o,
    input  logic [AW-1:0]    add_i,
    input  logic             wen_i,
    input  logic [DW/BW-1:0] be_i,
    input  logic [DW-1:0]    data_i,
    input  logic [IW-1:0]    id_i,
    output logic [DW-1:0]    r_data_o,
    output logic             r_valid_o,
    output logic [IW-1:0]    r_id_o,
    output logic             sram_req_o,
    output logic             sram_we_o,
    output logic [AW-1:0]    sram_addr_o,
    output logic [DW/BW-1:0] sram_be_o,
    output logic [DW-1:0]    sram_wdata_o,
    input  logic [DW-1:0]    sram_rdata_i,
    output logic             sram_sleep_o
);

    logic          w_active;
    logic          w_sram_req;
    logic          w_rd_gnt;
    logic          w_rvalid_d;
    logic [IW-1:0] w_rid_d;
    logic          r_rvalid;
    logic [IW-1:0] r_rid;

    hci_bank_sleep_fsm #(
        .IDLE_CYCLES (IDLE_CYCLES),
        .WAKE_CYCLES (WAKE_CYCLES)
    ) u_sleep_fsm (
        .i_clk    (clk_i),
        .i_rst_n  (rst_ni),
        .i_clear  (clear_i),
        .i_req    (req_i),
        .o_active (w_active),
        .o_sleep  (sram_sleep_o)
    );

    assign gnt_o        = req_i & w_active;
    assign w_sram_req   = req_i & gnt_o;
    assign sram_req_o   = w_sram_req;
    assign sram_we_o    = ~wen_i;
    assign sram_addr_o  = add_i;
    assign sram_be_o    = be_i;
    assign sram_wdata_o = data_i;

    assign w_rd_gnt = w_sram_req & wen_i;

    always_comb begin
        w_rvalid_d = w_rd_gnt & ~clear_i;
        w_rid_d    = w_rd_gnt ? id_i : r_rid;
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            r_rvalid <= 1'b0;
            r_rid    <= '0;
        end else begin
            r_rvalid <= w_rvalid_d;
            r_rid    <= w_rid_d;
        end
    end

    // SRAM read data is already aligned with the registered valid/id.
    assign r_data_o  = sram_rdata_i;
    assign r_valid_o = r_rvalid;
    assign r_id_o    = r_rid;

endmodule

// File: tb/tb_hci_mem_bank_ctrl.sv
// Directed bench for hci_mem_bank_ctrl; sleep/wake steps run when HCI_BANK_SLEEP_EN is defined.
module tb_hci_mem_bank_ctrl;

    localparam int unsigned AW = 32;
    localparam int unsigned DW = 32;
    localparam int unsigned BW = 8;
    localparam int unsigned IW = 20;

    logic             clk_i = 1'b0;
    logic             rst_ni;
    logic             clear_i;
    logic             req_i;
    logic             gnt_o;
    logic [AW-1:0]    add_i;
    logic             wen_i;
    logic [DW/BW-1:0] be_i;
    logic [DW-1:0]    data_i;
    logic [IW-1:0]    id_i;
    logic [DW-1:0]    r_data_o;
    logic             r_valid_o;
    logic [IW-1:0]    r_id_o;
    logic             sram_req_o;
    logic             sram_we_o;
    logic [AW-1:0]    sram_addr_o;
    logic [DW/BW-1:0] sram_be_o;
    logic [DW-1:0]    sram_wdata_o;
    logic [DW-1:0]    sram_rdata_i;
    logic             sram_sleep_o;

    int n_total = 0;
    int n_pass  = 0;

    hci_mem_bank_ctrl #(
        .AW          (AW),
        .DW          (DW),
        .BW          (BW),
        .IW          (IW),
        .IDLE_CYCLES (4),
        .WAKE_CYCLES (2)
    ) dut (
        .clk_i        (clk_i),
        .rst_ni       (rst_ni),
        .clear_i      (clear_i),
        .req_i        (req_i),
        .gnt_o        (gnt_o),
        .add_i        (add_i),
        .wen_i        (wen_i),
        .be_i         (be_i),
        .data_i       (data_i),
        .id_i         (id_i),
        .r_data_o     (r_data_o),
        .r_valid_o    (r_valid_o),
        .r_id_o       (r_id_o),
        .sram_req_o   (sram_req_o),
        .sram_we_o    (sram_we_o),
        .sram_addr_o  (sram_addr_o),
        .sram_be_o    (sram_be_o),
        .sram_wdata_o (sram_wdata_o),
        .sram_rdata_i (sram_rdata_i),
        .sram_sleep_o (sram_sleep_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic next_cyc();
        @(posedge clk_i);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    endtask

    task automatic drive_rd(input logic [AW-1:0] a, input logic [IW-1:0] id);
        req_i = 1'b1;
        wen_i = 1'b1;
        add_i = a;
        id_i  = id;
    endtask

    initial begin
        rst_ni       = 1'b0;
        clear_i      = 1'b0;
        req_i        = 1'b0;
        add_i        = '0;
        wen_i        = 1'b1;
        be_i         = '0;
        data_i       = '0;
        id_i         = '0;
        sram_rdata_i = '0;
        next_cyc();
        next_cyc();
        check("rst_rvalid", r_valid_o, 0);
        check("rst_rid", r_id_o, 0);
        check("rst_sleep", sram_sleep_o, 0);
        rst_ni = 1'b1;

        // Two back-to-back reads.
        drive_rd(32'h10, 20'd3);
        settle();
        check("rd0_gnt", gnt_o, 1);
        check("rd0_sram_req", sram_req_o, 1);
        check("rd0_we", sram_we_o, 0);
        check("rd0_addr", sram_addr_o, 32'h10);
        check("rd0_rvalid_lo", r_valid_o, 0);
        next_cyc();
        drive_rd(32'h14, 20'd5);
        sram_rdata_i = 32'hAAAA_0010;
        settle();
        check("rd0_rvalid", r_valid_o, 1);
        check("rd0_rid", r_id_o, 3);
        check("rd0_rdata", r_data_o, 32'hAAAA_0010);
        check("rd1_gnt", gnt_o, 1);

        // Write follows immediately; response of read 1 appears now.
        next_cyc();
        req_i        = 1'b1;
        wen_i        = 1'b0;
        be_i         = 4'b0011;
        data_i       = 32'hDEAD_BEEF;
        add_i        = 32'h20;
        id_i         = 20'd7;
        sram_rdata_i = 32'hBBBB_0014;
        settle();
        check("rd1_rvalid", r_valid_o, 1);
        check("rd1_rid", r_id_o, 5);
        check("rd1_rdata", r_data_o, 32'hBBBB_0014);
        check("wr_we", sram_we_o, 1);
        check("wr_be", sram_be_o, 4'b0011);
        check("wr_wdata", sram_wdata_o, 32'hDEAD_BEEF);
        check("wr_sram_req", sram_req_o, 1);

        next_cyc();
        req_i = 1'b0;
        wen_i = 1'b1;
        settle();
        check("wr_no_rvalid", r_valid_o, 0);
        check("idle_gnt", gnt_o, 0);
        check("idle_sram_req", sram_req_o, 0);

        // Clear suppresses the response of a read granted in the same cycle.
        next_cyc();
        drive_rd(32'h30, 20'd9);
        settle();
        check("rd2_gnt", gnt_o, 1);
        next_cyc();
        drive_rd(32'h34, 20'd11);
        clear_i = 1'b1;
        settle();
        check("rd2_rvalid", r_valid_o, 1);
        check("rd2_rid", r_id_o, 9);
        next_cyc();
        clear_i = 1'b0;
        req_i   = 1'b0;
        settle();
        check("clr_rvalid", r_valid_o, 0);

        // Reset drops an in-flight response and zeroes the id.
        next_cyc();
        drive_rd(32'h40, 20'h15);
        settle();
        next_cyc();
        rst_ni = 1'b0;
        req_i  = 1'b0;
        settle();
        check("rd3_rvalid", r_valid_o, 1);
        check("rd3_rid", r_id_o, 20'h15);
        next_cyc();
        rst_ni = 1'b1;
        settle();
        check("rst2_rvalid", r_valid_o, 0);
        check("rst2_rid", r_id_o, 0);

`ifdef HCI_BANK_SLEEP_EN
        // Idle cycles 1..4 are this one and the next three; sleep from the fifth.
        check("idle1_sleep", sram_sleep_o, 0);
        next_cyc();
        next_cyc();
        next_cyc();
        settle();
        check("idle4_sleep", sram_sleep_o, 0);
        next_cyc();
        settle();
        check("sleep_on", sram_sleep_o, 1);
        req_i = 1'b1;
        settle();
        check("sleep_no_gnt", gnt_o, 0);
        check("sleep_no_sram_req", sram_req_o, 0);
        next_cyc();
        settle();
        check("wake1_sleep", sram_sleep_o, 0);
        check("wake1_gnt", gnt_o, 0);
        next_cyc();
        settle();
        check("wake2_gnt", gnt_o, 0);
        next_cyc();
        drive_rd(32'h50, 20'h21);
        settle();
        check("wake_done_gnt", gnt_o, 1);
        next_cyc();
        req_i = 1'b0;
        settle();
        check("wake_rd_rvalid", r_valid_o, 1);
        check("wake_rd_rid", r_id_o, 20'h21);

        // Request pulses for one cycle, then drops during wake.
        next_cyc();
        next_cyc();
        next_cyc();
        next_cyc();
        settle();
        check("sleep2_on", sram_sleep_o, 1);
        req_i = 1'b1;
        next_cyc();
        req_i = 1'b0;
        settle();
        check("wake_drop_sleep", sram_sleep_o, 0);
        check("wake_drop_rvalid", r_valid_o, 0);
        next_cyc();
        settle();
        check("wake_drop2_sleep", sram_sleep_o, 0);
        check("wake_drop2_rvalid", r_valid_o, 0);
        next_cyc();
        drive_rd(32'h60, 20'h22);
        settle();
        check("wake_drop_active_gnt", gnt_o, 1);
        check("wake_drop_active_sleep", sram_sleep_o, 0);

        // Clear out of sleep with a pending request grants in the next cycle.
        next_cyc();
        req_i = 1'b0;
        next_cyc();
        next_cyc();
        next_cyc();
        next_cyc();
        settle();
        check("sleep3_on", sram_sleep_o, 1);
        req_i   = 1'b1;
        clear_i = 1'b1;
        settle();
        check("clr_sleep_gnt", gnt_o, 0);
        next_cyc();
        clear_i = 1'b0;
        settle();
        check("clr_active_gnt", gnt_o, 1);
        check("clr_active_sleep", sram_sleep_o, 0);
`else
        for (int i = 0; i < 100; i++) begin
            settle();
            check("nosleep_idle", sram_sleep_o, 0);
            next_cyc();
        end
        for (int i = 0; i < 6; i++) begin
            req_i = i[0];
            settle();
            check("nosleep_gnt_follows", gnt_o, i[0]);
            check("nosleep_sleep", sram_sleep_o, 0);
            next_cyc();
        end
`endif

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
